// File: rtl/dct_qz_pkg.sv
// Constants shared by the quantise/zigzag stage: JPEG luma table, reciprocals, zigzag maps
// and the output FSM state type.
package dct_qz_pkg;

  localparam int unsigned CW = 12;
  localparam int unsigned RW = 16;
  localparam int unsigned OW = 12;

  typedef enum logic {StIdle, StStream} qz_state_e;

  // Raster-order tables, entry 0 in the most significant byte.
  localparam logic [511:0] QTAB_FLAT = {
    8'd16,  8'd11,  8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
    8'd12,  8'd12,  8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
    8'd14,  8'd13,  8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
    8'd14,  8'd17,  8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
    8'd18,  8'd22,  8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
    8'd24,  8'd35,  8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
    8'd49,  8'd64,  8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
    8'd72,  8'd92,  8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
  };

  localparam logic [511:0] ZZ_FLAT = {
    8'd0,  8'd1,  8'd8,  8'd16, 8'd9,  8'd2,  8'd3,  8'd10,
    8'd17, 8'd24, 8'd32, 8'd25, 8'd18, 8'd11, 8'd4,  8'd5,
    8'd12, 8'd19, 8'd26, 8'd33, 8'd40, 8'd48, 8'd41, 8'd34,
    8'd27, 8'd20, 8'd13, 8'd6,  8'd7,  8'd14, 8'd21, 8'd28,
    8'd35, 8'd42, 8'd49, 8'd56, 8'd57, 8'd50, 8'd43, 8'd36,
    8'd29, 8'd22, 8'd15, 8'd23, 8'd30, 8'd37, 8'd44, 8'd51,
    8'd58, 8'd59, 8'd52, 8'd45, 8'd38, 8'd31, 8'd39, 8'd46,
    8'd53, 8'd60, 8'd61, 8'd54, 8'd47, 8'd55, 8'd62, 8'd63
  };

  function automatic logic [63:0][7:0] gen_qtab();
    logic [63:0][7:0] t;
    for (int i = 0; i < 64; i++) t[i] = QTAB_FLAT[(63 - i) * 8 +: 8];
    return t;
  endfunction

  localparam logic [63:0][7:0] QTAB = gen_qtab();

  // Round-to-nearest reciprocal in Q0.16.
  function automatic logic [63:0][RW-1:0] gen_recip();
    logic [63:0][RW-1:0] t;
    int unsigned q;
    for (int i = 0; i < 64; i++) begin
      q    = 32'(QTAB[i]);
      t[i] = RW'((32'd65536 + q / 2) / q);
    end
    return t;
  endfunction

  localparam logic [63:0][RW-1:0] RECIP = gen_recip();

  function automatic logic [63:0][5:0] gen_zz();
    logic [63:0][5:0] t;
    for (int i = 0; i < 64; i++) t[i] = ZZ_FLAT[(63 - i) * 8 +: 6];
    return t;
  endfunction

  localparam logic [63:0][5:0] ZZ = gen_zz();

  function automatic logic [63:0][5:0] gen_izz();
    logic [63:0][5:0] t;
    t = '0;
    for (int i = 0; i < 64; i++) t[ZZ[i]] = 6'(i);
    return t;
  endfunction

  localparam logic [63:0][5:0] IZZ = gen_izz();

endpackage

// File: rtl/dct_qz_row.sv
// Combinational row quantiser: 8 lanes of sign-magnitude reciprocal multiply, round half up.
module dct_qz_row
  import dct_qz_pkg::*;
(
  input  logic [8*CW-1:0] row,
  input  logic [2:0]      row_idx,
  output logic [8*OW-1:0] q
);

  localparam int unsigned PW = CW + RW;

  for (genvar c = 0; c < 8; c++) begin : g_lane
    logic [CW-1:0] coef;
    logic [CW-1:0] mag;
    logic [PW-1:0] sum;
    logic [OW-1:0] res;

    assign coef = row[c*CW +: CW];
    // -2048 negates to 0x800, which is the correct magnitude read unsigned.
    assign mag  = coef[CW-1] ? (~coef + CW'(1)) : coef;
    assign sum  = PW'(mag) * PW'(RECIP[{row_idx, 3'(c)}]) + PW'(1 << (RW - 1));
    assign res  = OW'(sum >> RW);
    assign q[c*OW +: OW] = coef[CW-1] ? (~res + OW'(1)) : res;
  end

endmodule

// File: rtl/dct_quant_zigzag.sv
// Quantise DCT rows, buffer 8x8 blocks in a ping-pong bank and stream them in zigzag order.
// Define DCT_QZ_EOB_EN to add the out_eob last-nonzero marker.
module dct_quant_zigzag
  import dct_qz_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [8*CW-1:0] in_row,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_coef,
  output logic [5:0]    out_idx,
  output logic          out_last
`ifdef DCT_QZ_EOB_EN
  ,
  output logic          out_eob
`endif
);

  logic [2:0]      row_cnt_q, row_sel;
  logic            wr_bank_q, rd_bank_q, rd_bank_d;
  logic [1:0]      full_q;
  logic            q_valid_q, q_last_q;
  logic [2:0]      q_row_q;
  logic [8*OW-1:0] q_row_data, q_data_q;
  logic [OW-1:0]   mem [2][64];
  qz_state_e       state_q, state_d;
  logic            load, load_bank, free, in_fire;
  logic [5:0]      load_idx;

  dct_qz_row u_row (
    .row     (in_row),
    .row_idx (row_sel),
    .q       (q_row_data)
  );

  assign in_ready = !full_q[wr_bank_q] && !(q_valid_q && q_last_q);
  assign in_fire  = in_valid && in_ready;
  // A mid-block SOF restarts the same bank at row 0.
  assign row_sel  = in_sof ? 3'd0 : row_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt_q <= '0;
      wr_bank_q <= 1'b0;
      q_valid_q <= 1'b0;
      q_last_q  <= 1'b0;
      q_row_q   <= '0;
      q_data_q  <= '0;
    end else begin
      q_valid_q <= in_fire;
      if (in_fire) begin
        row_cnt_q <= row_sel + 3'd1;
        q_last_q  <= (row_sel == 3'd7);
        q_row_q   <= row_sel;
        q_data_q  <= q_row_data;
      end
      if (q_valid_q && q_last_q) wr_bank_q <= ~wr_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (q_valid_q) begin
      for (int c = 0; c < 8; c++) mem[wr_bank_q][{q_row_q, 3'(c)}] <= q_data_q[c*OW +: OW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= '0;
    end else begin
      if (free) full_q[rd_bank_q] <= 1'b0;
      if (q_valid_q && q_last_q) full_q[wr_bank_q] <= 1'b1;
    end
  end

`ifdef DCT_QZ_EOB_EN
  logic [5:0] eob_max_q [2];
  logic [5:0] row_max;

  always_comb begin
    row_max = 6'd0;
    for (int c = 0; c < 8; c++) begin
      if (q_data_q[c*OW +: OW] != '0 && IZZ[{q_row_q, 3'(c)}] > row_max) begin
        row_max = IZZ[{q_row_q, 3'(c)}];
      end
    end
  end

  // Row 0 write re-seeds the tracker, so a discarded partial block leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eob_max_q[0] <= '0;
      eob_max_q[1] <= '0;
    end else if (q_valid_q) begin
      if (q_row_q == 3'd0 || row_max > eob_max_q[wr_bank_q]) eob_max_q[wr_bank_q] <= row_max;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    load      = 1'b0;
    load_bank = rd_bank_q;
    load_idx  = 6'd0;
    free      = 1'b0;
    case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          load    = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        if (out_ready) begin
          if (out_last) begin
            free      = 1'b1;
            rd_bank_d = ~rd_bank_q;
            if (full_q[~rd_bank_q]) begin
              load      = 1'b1;
              load_bank = ~rd_bank_q;
            end else begin
              state_d = StIdle;
            end
          end else begin
            load     = 1'b1;
            load_idx = out_idx + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rd_bank_q <= 1'b0;
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
`ifdef DCT_QZ_EOB_EN
      out_eob   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      if (load) begin
        out_valid <= 1'b1;
        out_coef  <= mem[load_bank][ZZ[load_idx]];
        out_idx   <= load_idx;
        out_last  <= &load_idx;
`ifdef DCT_QZ_EOB_EN
        out_eob   <= (load_idx == eob_max_q[load_bank]);
`endif
      end else if (free) begin
        out_valid <= 1'b0;
        out_coef  <= '0;
        out_idx   <= '0;
        out_last  <= 1'b0;
`ifdef DCT_QZ_EOB_EN
        out_eob   <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Directed bench for dct_quant_zigzag; out_eob is checked when DCT_QZ_EOB_EN is defined.
module tb_dct_quant_zigzag;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sof;
  logic [95:0] in_row;
  logic        out_valid, out_ready, out_last, eob_s;
  logic [11:0] out_coef;
  logic [5:0]  out_idx;

  int tests = 0;
  int fails = 0;

  logic [11:0] b_coef[$];
  logic [5:0]  b_idx[$];
  logic        b_last[$];
  logic        b_eob[$];
  int          acc_count = 0;
  int          gaps = 0;
  logic        gap_watch = 1'b0;

`ifdef DCT_QZ_EOB_EN
  logic out_eob;
  assign eob_s = out_eob;
`else
  assign eob_s = 1'b0;
`endif

  dct_quant_zigzag dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef DCT_QZ_EOB_EN
    ,
    .out_eob   (out_eob)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge sees settled handshakes.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      b_coef.push_back(out_coef);
      b_idx.push_back(out_idx);
      b_last.push_back(out_last);
      b_eob.push_back(eob_s);
    end
    if (in_valid && in_ready) acc_count++;
    if (gap_watch && out_ready && !out_valid) gaps++;
  end

  function automatic logic [95:0] mk_row(input int c0, input int c7);
    logic [95:0] r;
    r = '0;
    r[11:0]  = 12'(c0);
    r[95:84] = 12'(c7);
    return r;
  endfunction

  task automatic send_row(input logic [95:0] r, input logic sof);
    int n = 0;
    in_valid = 1'b1;
    in_row   = r;
    in_sof   = sof;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_row: in_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_block(input logic [95:0] r0, input logic [95:0] r1, input logic [95:0] r7);
    send_row(r0, 1'b1);
    send_row(r1, 1'b0);
    for (int r = 2; r < 7; r++) send_row('0, 1'b0);
    send_row(r7, 1'b0);
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (b_coef.size() < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic test_reset();
    tests++;
    if (out_valid !== 1'b0 || out_coef !== 12'd0 || out_idx !== 6'd0 || out_last !== 1'b0)
    begin
      fails++;
      $display("FAIL reset_outputs: valid=%b coef=%0d idx=%0d last=%b, required all 0",
               out_valid, out_coef, out_idx, out_last);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL after_reset_idle: valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_dc_only();
    int base;
    logic [11:0] exp_c [64];
    base = b_coef.size();
    for (int i = 0; i < 64; i++) exp_c[i] = 12'd0;
    exp_c[0] = 12'd63;
    out_ready = 1'b1;
    send_block(mk_row(1000, 0), '0, '0);
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL dc_latency_early: out_valid=%b required 0", out_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 6'd0) begin
      fails++;
      $display("FAIL dc_latency: valid=%b idx=%0d required 1/0", out_valid, out_idx);
    end
    wait_beats(base + 64);
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (b_coef.size() - base !== 64) begin
      fails++; $display("FAIL dc_count: got %0d beats required 64", b_coef.size() - base);
    end
    for (int i = 0; i < 64 && base + i < b_coef.size(); i++) begin
      tests++;
      if (b_idx[base+i] !== 6'(i) || b_coef[base+i] !== exp_c[i] || b_last[base+i] !== (i == 63))
      begin
        fails++;
        $display("FAIL dc_beat %0d: idx=%0d coef=%0d last=%b, required idx=%0d coef=%0d last=%b",
                 i, b_idx[base+i], $signed(b_coef[base+i]), b_last[base+i], i,
                 $signed(exp_c[i]), (i == 63));
      end
`ifdef DCT_QZ_EOB_EN
      tests++;
      if (b_eob[base+i] !== (i == 0)) begin
        fails++; $display("FAIL dc_eob %0d: got %b required %b", i, b_eob[base+i], (i == 0));
      end
`endif
    end
  endtask

  task automatic test_min_neg();
    int base;
    logic [11:0] exp_c [64];
    base = b_coef.size();
    for (int i = 0; i < 64; i++) exp_c[i] = 12'd0;
    exp_c[0] = 12'hF80;
    send_block(mk_row(-2048, 0), '0, '0);
    wait_beats(base + 64);
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (b_coef.size() - base !== 64) begin
      fails++; $display("FAIL neg_count: got %0d beats required 64", b_coef.size() - base);
    end
    for (int i = 0; i < 64 && base + i < b_coef.size(); i++) begin
      tests++;
      if (b_idx[base+i] !== 6'(i) || b_coef[base+i] !== exp_c[i]) begin
        fails++;
        $display("FAIL neg_beat %0d: idx=%0d coef=%0d, required idx=%0d coef=%0d", i,
                 b_idx[base+i], $signed(b_coef[base+i]), i, $signed(exp_c[i]));
      end
    end
  endtask

  task automatic test_single_ac();
    int base;
    logic [11:0] exp_c [64];
    base = b_coef.size();
    for (int i = 0; i < 64; i++) exp_c[i] = 12'd0;
    exp_c[2] = 12'd10;
    send_block('0, mk_row(120, 0), '0);
    wait_beats(base + 64);
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (b_coef.size() - base !== 64) begin
      fails++; $display("FAIL ac_count: got %0d beats required 64", b_coef.size() - base);
    end
    for (int i = 0; i < 64 && base + i < b_coef.size(); i++) begin
      tests++;
      if (b_idx[base+i] !== 6'(i) || b_coef[base+i] !== exp_c[i] || b_last[base+i] !== (i == 63))
      begin
        fails++;
        $display("FAIL ac_beat %0d: idx=%0d coef=%0d last=%b, required idx=%0d coef=%0d", i,
                 b_idx[base+i], $signed(b_coef[base+i]), b_last[base+i], i, $signed(exp_c[i]));
      end
`ifdef DCT_QZ_EOB_EN
      tests++;
      if (b_eob[base+i] !== (i == 2)) begin
        fails++; $display("FAIL ac_eob %0d: got %b required %b", i, b_eob[base+i], (i == 2));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int base, acc0, gap0, k;
    logic [11:0] exp;
    base = b_coef.size();
    acc0 = acc_count;
    gap0 = gaps;
    out_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 3; b++) send_block(mk_row(160 * (b + 1), 0), '0, mk_row(0, -990));
      end
      begin
        k = 0;
        while (acc_count - acc0 < 16 && k < 1000) begin
          @(posedge clk);
          k++;
        end
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (acc_count - acc0 !== 16) begin
          fails++; $display("FAIL bp_rows: accepted %0d rows required 16", acc_count - acc0);
        end
        tests++;
        if (in_ready !== 1'b0) begin
          fails++; $display("FAIL bp_in_ready: got %b required 0", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        gap_watch = 1'b1;
        wait_beats(base + 192);
        gap_watch = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (b_coef.size() - base !== 192) begin
      fails++; $display("FAIL bp_count: got %0d beats required 192", b_coef.size() - base);
    end
    tests++;
    if (gaps - gap0 !== 0) begin
      fails++; $display("FAIL bp_gaps: got %0d idle cycles required 0", gaps - gap0);
    end
    for (int k2 = 0; k2 < 192 && base + k2 < b_coef.size(); k2++) begin
      exp = (k2 % 64 == 0) ? 12'(10 * (k2 / 64 + 1)) : (k2 % 64 == 63) ? 12'hFF6 : 12'd0;
      tests++;
      if (b_idx[base+k2] !== 6'(k2 % 64) || b_coef[base+k2] !== exp ||
          b_last[base+k2] !== (k2 % 64 == 63)) begin
        fails++;
        $display("FAIL bp_beat %0d: idx=%0d coef=%0d last=%b, required idx=%0d coef=%0d", k2,
                 b_idx[base+k2], $signed(b_coef[base+k2]), b_last[base+k2], k2 % 64,
                 $signed(exp));
      end
`ifdef DCT_QZ_EOB_EN
      tests++;
      if (b_eob[base+k2] !== (k2 % 64 == 63)) begin
        fails++; $display("FAIL bp_eob %0d: got %b", k2, b_eob[base+k2]);
      end
`endif
    end
  endtask

  task automatic test_sof_discard();
    int base;
    logic [11:0] exp_c [64];
    base = b_coef.size();
    for (int i = 0; i < 64; i++) exp_c[i] = 12'd0;
    exp_c[0] = 12'd10;
    exp_c[2] = 12'd10;
    send_row(mk_row(800, 0), 1'b1);
    for (int r = 1; r < 4; r++) send_row(mk_row(240, 0), 1'b0);
    send_block(mk_row(160, 0), mk_row(120, 0), '0);
    wait_beats(base + 64);
    repeat (60) @(posedge clk);
    #1;
    tests++;
    if (b_coef.size() - base !== 64) begin
      fails++; $display("FAIL sof_count: got %0d beats required 64", b_coef.size() - base);
    end
    for (int i = 0; i < 64 && base + i < b_coef.size(); i++) begin
      tests++;
      if (b_idx[base+i] !== 6'(i) || b_coef[base+i] !== exp_c[i]) begin
        fails++;
        $display("FAIL sof_beat %0d: idx=%0d coef=%0d, required idx=%0d coef=%0d", i,
                 b_idx[base+i], $signed(b_coef[base+i]), i, $signed(exp_c[i]));
      end
`ifdef DCT_QZ_EOB_EN
      tests++;
      if (b_eob[base+i] !== (i == 2)) begin
        fails++; $display("FAIL sof_eob %0d: got %b required %b", i, b_eob[base+i], (i == 2));
      end
`endif
    end
  endtask

  task automatic test_reset_midstream();
    int base;
    out_ready = 1'b0;
    send_block(mk_row(1000, 0), '0, '0);
    send_row(mk_row(500, 0), 1'b1);
    send_row('0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL mid_stalled: out_valid=%b required 1", out_valid);
    end
    rst_n = 1'b0;
    #2;
    tests++;
    if (out_valid !== 1'b0 || out_coef !== 12'd0 || out_idx !== 6'd0 || out_last !== 1'b0)
    begin
      fails++;
      $display("FAIL mid_reset_outputs: valid=%b coef=%0d idx=%0d last=%b, required all 0",
               out_valid, out_coef, out_idx, out_last);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset_in_ready: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    base      = b_coef.size();
    repeat (100) @(posedge clk);
    #1;
    tests++;
    if (b_coef.size() - base !== 0) begin
      fails++; $display("FAIL mid_no_beats: got %0d beats required 0", b_coef.size() - base);
    end
    send_block('0, mk_row(120, 0), '0);
    wait_beats(base + 64);
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (b_coef.size() - base !== 64) begin
      fails++; $display("FAIL mid_recover_count: got %0d required 64", b_coef.size() - base);
    end
    if (b_coef.size() - base >= 3) begin
      tests++;
      if (b_coef[base] !== 12'd0 || b_coef[base+2] !== 12'd10 || b_idx[base+2] !== 6'd2) begin
        fails++;
        $display("FAIL mid_recover_data: c0=%0d c2=%0d idx2=%0d, required 0/10/2",
                 $signed(b_coef[base]), $signed(b_coef[base+2]), b_idx[base+2]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_row    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_dc_only();
    test_min_neg();
    test_single_ac();
    test_back_to_back();
    test_sof_discard();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
